// File: rtl/edge_tx_if.sv
// Event offer handshake between an event source and the edge_tx transmitter.
// The source drives ev_valid; the transmitter answers with ev_ready.
interface edge_tx_if;
  logic ev_valid;
  logic ev_ready;

  modport master (output ev_valid, input ev_ready);
  modport slave  (input ev_valid, output ev_ready);
endinterface

// File: rtl/edge_tx.sv
// Dual-edge signalling transmitter: one transition on `out` per accepted event,
// paced at least HOLD cycles apart, with a saturating pending-event counter.
module edge_tx #(
  parameter int HOLD  = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  edge_tx_if.slave         ev,
  input  logic             clr,
  output logic             out,
  output logic [CNT_W-1:0] pending,
  output logic             busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_t;

  localparam logic [7:0]       HOLD_M1   = 8'(HOLD - 1);
  localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PEND_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [7:0]       timer_r;
  logic             out_r;
  logic [CNT_W-1:0] pending_r;

  logic ready_s;
  logic accept_s;
  logic avail_s;
  logic emit_s;

  // Handshake decode and the decision whether an edge is emitted this cycle
  always_comb begin
    ready_s  = (pending_r != PEND_MAX) && !clr;
    accept_s = ev.ev_valid && ready_s;
    // An event arriving this cycle counts as available, so idle latency is zero.
    avail_s  = (pending_r != PEND_ZERO) || accept_s;
    emit_s   = 1'b0;
    if (clr) begin
      emit_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    emit_s = avail_s;
        GAP:     emit_s = avail_s && (timer_r == 8'd0);
        default: emit_s = 1'b0;
      endcase
    end
  end

  // State machine, toggle line, gap timer and pending-event counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      timer_r   <= 8'd0;
      out_r     <= 1'b0;
      pending_r <= PEND_ZERO;
    end else if (clr) begin
      // Flush leaves the line level untouched; only bookkeeping is cleared.
      state_r   <= IDLE;
      timer_r   <= 8'd0;
      out_r     <= out_r;
      pending_r <= PEND_ZERO;
    end else begin
      case ({accept_s, emit_s})
        2'b10:   pending_r <= pending_r + PEND_ONE;
        2'b01:   pending_r <= pending_r - PEND_ONE;
        default: pending_r <= pending_r;
      endcase

      case (state_r)
        IDLE: begin
          if (emit_s) begin
            out_r   <= ~out_r;
            timer_r <= HOLD_M1;
            state_r <= GAP;
          end else begin
            state_r <= IDLE;
          end
        end
        GAP: begin
          if (timer_r != 8'd0) begin
            timer_r <= timer_r - 8'd1;
          end else if (emit_s) begin
            // Back-to-back edge: reload so edges stay exactly HOLD cycles apart.
            out_r   <= ~out_r;
            timer_r <= HOLD_M1;
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          timer_r <= 8'd0;
        end
      endcase
    end
  end

  assign ev.ev_ready = ready_s;
  assign out         = out_r;
  assign pending     = pending_r;
  assign busy        = (state_r == GAP) || (pending_r != PEND_ZERO);

endmodule

// File: tb/tb_edge_tx.sv
// Directed bench for edge_tx: three instances cover HOLD=2, HOLD=3 and a
// narrow CNT_W=2/HOLD=4 counter for saturation.
module tb_edge_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr2, clr3, clr4;
  logic       out2, out3, out4;
  logic [3:0] pend2, pend3;
  logic [1:0] pend4;
  logic       busy2, busy3, busy4;
  int         checks = 0;
  int         errors = 0;

  edge_tx_if if2 ();
  edge_tx_if if3 ();
  edge_tx_if if4 ();

  always #5 clk = ~clk;

  edge_tx #(.HOLD(2), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .ev(if2), .clr(clr2),
    .out(out2), .pending(pend2), .busy(busy2)
  );
  edge_tx #(.HOLD(3), .CNT_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .ev(if3), .clr(clr3),
    .out(out3), .pending(pend3), .busy(busy3)
  );
  edge_tx #(.HOLD(4), .CNT_W(2)) u4 (
    .clk(clk), .rst_n(rst_n), .ev(if4), .clr(clr4),
    .out(out4), .pending(pend4), .busy(busy4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    tick();
    tick();
    checks++; if (out2 !== 1'b0) begin errors++; $display("FAIL reset_out: got %0d expected 0", out2); end
    checks++; if (pend2 !== 4'd0) begin errors++; $display("FAIL reset_pending: got %0d expected 0", pend2); end
    checks++; if (if2.ev_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0d expected 1", if2.ev_ready); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d expected 0", busy2); end
    rst_n = 1'b1;
    tick();
    checks++; if (if2.ev_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %0d expected 1", if2.ev_ready); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL release_busy: got %0d expected 0", busy2); end
  endtask

  task automatic test_single;
    int busy_cycles;
    if2.ev_valid = 1'b1;
    tick();
    if2.ev_valid = 1'b0;
    checks++; if (out2 !== 1'b1) begin errors++; $display("FAIL single_rise: got %0d expected 1", out2); end
    checks++; if (pend2 !== 4'd0) begin errors++; $display("FAIL single_pending: got %0d expected 0", pend2); end
    busy_cycles = 0;
    for (int c = 0; c < 6; c++) begin
      if (busy2 === 1'b1) busy_cycles++;
      tick();
    end
    checks++; if (busy_cycles !== 2) begin errors++; $display("FAIL single_busy_len: got %0d expected 2", busy_cycles); end
    checks++; if (out2 !== 1'b1) begin errors++; $display("FAIL single_hold_level: got %0d expected 1", out2); end
  endtask

  task automatic test_burst;
    logic [3:0] exp_p [14];
    int   acc, trans, last, peak, pulses;
    logic prev, d1, d2;
    exp_p = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0};
    apply_reset();
    acc = 0; trans = 0; last = -1; peak = 0; pulses = 0;
    prev = out3; d1 = out3; d2 = out3;
    for (int c = 0; c < 20; c++) begin
      if3.ev_valid = (c < 5) ? 1'b1 : 1'b0;
      if (if3.ev_valid && if3.ev_ready) acc++;
      tick();
      if (c < 14) begin
        checks++; if (pend3 !== exp_p[c]) begin errors++; $display("FAIL burst_pending[%0d]: got %0d expected %0d", c, pend3, exp_p[c]); end
      end
      if (int'(pend3) > peak) peak = int'(pend3);
      if (out3 !== prev) begin
        if (last >= 0) begin
          checks++; if (c - last !== 3) begin errors++; $display("FAIL burst_spacing: got %0d expected 3", c - last); end
        end
        trans++;
        last = c;
      end
      prev = out3;
      // two-flop XOR detector model
      d2 = d1;
      d1 = out3;
      if (d1 ^ d2) pulses++;
    end
    if3.ev_valid = 1'b0;
    checks++; if (acc !== 5) begin errors++; $display("FAIL burst_accepted: got %0d expected 5", acc); end
    checks++; if (trans !== 5) begin errors++; $display("FAIL burst_transitions: got %0d expected 5", trans); end
    checks++; if (pulses !== 5) begin errors++; $display("FAIL burst_detector: got %0d expected 5", pulses); end
    checks++; if (peak !== 3) begin errors++; $display("FAIL burst_peak: got %0d expected 3", peak); end
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL burst_idle: got %0d expected 0", busy3); end
  endtask

  task automatic test_saturation;
    int   acc, trans, last;
    logic prev, want_ready;
    apply_reset();
    acc = 0; trans = 0; last = -1; prev = out4;
    for (int c = 0; c < 30; c++) begin
      if4.ev_valid = (c < 10) ? 1'b1 : 1'b0;
      want_ready = (pend4 != 2'd3) ? 1'b1 : 1'b0;
      checks++; if (if4.ev_ready !== want_ready) begin errors++; $display("FAIL sat_ready[%0d]: got %0d expected %0d", c, if4.ev_ready, want_ready); end
      if (if4.ev_valid && if4.ev_ready) acc++;
      tick();
      if (out4 !== prev) begin
        if (last >= 0) begin
          checks++; if (c - last !== 4) begin errors++; $display("FAIL sat_spacing: got %0d expected 4", c - last); end
        end
        trans++;
        last = c;
      end
      prev = out4;
    end
    if4.ev_valid = 1'b0;
    checks++; if (acc !== 6) begin errors++; $display("FAIL sat_accepted: got %0d expected 6", acc); end
    checks++; if (trans !== acc) begin errors++; $display("FAIL sat_transitions: got %0d expected %0d", trans, acc); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL sat_idle: got %0d expected 0", busy4); end
  endtask

  task automatic test_flush;
    int   changes;
    logic prev;
    apply_reset();
    if3.ev_valid = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    if3.ev_valid = 1'b0;
    checks++; if (out3 !== 1'b1) begin errors++; $display("FAIL flush_first_edge: got %0d expected 1", out3); end
    checks++; if (pend3 !== 4'd2) begin errors++; $display("FAIL flush_queued: got %0d expected 2", pend3); end
    clr3 = 1'b1;
    #1;
    checks++; if (if3.ev_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_blocked: got %0d expected 0", if3.ev_ready); end
    tick();
    clr3 = 1'b0;
    checks++; if (pend3 !== 4'd0) begin errors++; $display("FAIL flush_pending: got %0d expected 0", pend3); end
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL flush_idle: got %0d expected 0", busy3); end
    checks++; if (out3 !== 1'b1) begin errors++; $display("FAIL flush_level: got %0d expected 1", out3); end
    changes = 0; prev = out3;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out3 !== prev) changes++;
      prev = out3;
    end
    checks++; if (changes !== 0) begin errors++; $display("FAIL flush_quiet: got %0d expected 0", changes); end
    if3.ev_valid = 1'b1;
    tick();
    if3.ev_valid = 1'b0;
    checks++; if (out3 !== 1'b0) begin errors++; $display("FAIL flush_next_toggle: got %0d expected 0", out3); end
    checks++; if (pend3 !== 4'd0) begin errors++; $display("FAIL flush_next_pending: got %0d expected 0", pend3); end
  endtask

  task automatic test_simultaneous;
    apply_reset();
    if3.ev_valid = 1'b1;
    tick();
    tick();
    if3.ev_valid = 1'b0;
    tick();
    checks++; if (pend3 !== 4'd1) begin errors++; $display("FAIL simul_pre_pending: got %0d expected 1", pend3); end
    checks++; if (out3 !== 1'b1) begin errors++; $display("FAIL simul_pre_out: got %0d expected 1", out3); end
    if3.ev_valid = 1'b1;
    tick();
    if3.ev_valid = 1'b0;
    checks++; if (out3 !== 1'b0) begin errors++; $display("FAIL simul_toggle: got %0d expected 0", out3); end
    checks++; if (pend3 !== 4'd1) begin errors++; $display("FAIL simul_pending: got %0d expected 1", pend3); end
    checks++; if (if3.ev_ready !== 1'b1) begin errors++; $display("FAIL simul_ready: got %0d expected 1", if3.ev_ready); end
  endtask

  task automatic test_async_reset;
    int   changes;
    logic prev;
    apply_reset();
    if3.ev_valid = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    if3.ev_valid = 1'b0;
    checks++; if (out3 !== 1'b1) begin errors++; $display("FAIL async_pre_out: got %0d expected 1", out3); end
    checks++; if (pend3 !== 4'd2) begin errors++; $display("FAIL async_pre_pending: got %0d expected 2", pend3); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out3 !== 1'b0) begin errors++; $display("FAIL async_out: got %0d expected 0", out3); end
    checks++; if (pend3 !== 4'd0) begin errors++; $display("FAIL async_pending: got %0d expected 0", pend3); end
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL async_busy: got %0d expected 0", busy3); end
    checks++; if (if3.ev_ready !== 1'b1) begin errors++; $display("FAIL async_ready: got %0d expected 1", if3.ev_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    changes = 0; prev = out3;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out3 !== prev) changes++;
      prev = out3;
    end
    checks++; if (changes !== 0) begin errors++; $display("FAIL async_no_spurious: got %0d expected 0", changes); end
    checks++; if (pend3 !== 4'd0) begin errors++; $display("FAIL async_post_pending: got %0d expected 0", pend3); end
  endtask

  initial begin
    rst_n = 1'b0;
    clr2 = 1'b0; clr3 = 1'b0; clr4 = 1'b0;
    if2.ev_valid = 1'b0; if3.ev_valid = 1'b0; if4.ev_valid = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_saturation();
    test_flush();
    test_simultaneous();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
